// File: rtl/dmem_mmio_responder.sv
// ---------------------------------------------------------------------------
// dmem_mmio_responder
//
// Memory-side responder for a core with split instruction/data ports.
// A single word RAM serves instruction fetches and data reads with zero
// latency and absorbs data writes. Three memory-mapped addresses sit
// outside the RAM region:
//   SIG_ADDR  (write) : push a signature word into a small FIFO
//   STAT_ADDR (read)  : {halted, sig_overflow, 14'b0, FIFO count[15:0]}
//   HALT_ADDR (write) : with data HALT_DATA, stops the responder
// The signature FIFO drains over a valid/ready stream so the signature and
// halt protocol also works on hardware, e.g. behind a UART.
//
// Ports
//   sysclk        system clock, rising edge
//   nrst_in       asynchronous active-low reset (control state only)
//   imem_addr     instruction fetch byte address
//   imem_data     instruction word, combinational (NOP outside RAM region)
//   dmem_rd_addr  data read byte address
//   dmem_rd_data  data read word, combinational
//   dmem_wr_addr  data write byte address
//   dmem_wr_data  data write word
//   dmem_wr_en    write strobe, sampled on the rising edge of sysclk
//   sig_valid     signature word available at sig_data
//   sig_data      FIFO head word (0 while empty)
//   sig_ready     downstream accepts sig_data
//   sig_overflow  sticky: a signature write found the FIFO full
//   halted        sticky: a qualifying halt write was seen
//   done          halted and the signature FIFO has drained
// ---------------------------------------------------------------------------
module dmem_mmio_responder #(
  parameter int          MEMSIZE   = 32,
  parameter int          SIG_DEPTH = 8,
  parameter logic [31:0] SIG_ADDR  = 32'hF000_0004,
  parameter logic [31:0] STAT_ADDR = 32'hF000_0008,
  parameter logic [31:0] HALT_ADDR = 32'hCAFE_CAFE,
  parameter logic [31:0] HALT_DATA = 32'hF000_0000
) (
  input  logic        sysclk,
  input  logic        nrst_in,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  input  logic [31:0] dmem_rd_addr,
  output logic [31:0] dmem_rd_data,
  input  logic [31:0] dmem_wr_addr,
  input  logic [31:0] dmem_wr_data,
  input  logic        dmem_wr_en,
  output logic        sig_valid,
  output logic [31:0] sig_data,
  input  logic        sig_ready,
  output logic        sig_overflow,
  output logic        halted,
  output logic        done
);

  localparam int          DATA_W = 32;
  localparam int          AW     = $clog2(MEMSIZE);
  localparam int          PW     = $clog2(SIG_DEPTH);
  localparam int          CW     = PW + 1;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  // Storage arrays carry no reset; RAM contents survive nrst_in.
  logic [DATA_W-1:0] ram      [MEMSIZE];
  logic [DATA_W-1:0] sig_fifo [SIG_DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] sig_count;

  logic [AW-1:0] imem_idx;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;

  logic imem_in_ram;
  logic rd_in_ram;
  logic wr_in_ram;
  logic wr_ok;
  logic ram_wr;
  logic sig_wr;
  logic halt_wr;
  logic sig_full;
  logic push;
  logic pop;
  logic unused_imem_bits;

  // Address decode: RAM region is the bottom 256 MB; upper index bits and
  // byte offsets are ignored, so RAM aliases every MEMSIZE words.
  assign imem_in_ram = (imem_addr[31:28] == 4'h0);
  assign rd_in_ram   = (dmem_rd_addr[31:28] == 4'h0);
  assign wr_in_ram   = (dmem_wr_addr[31:28] == 4'h0);
  assign imem_idx    = imem_addr[AW+1:2];
  assign rd_idx      = dmem_rd_addr[AW+1:2];
  assign wr_idx      = dmem_wr_addr[AW+1:2];

  assign unused_imem_bits = ^{imem_addr[27:AW+2], imem_addr[1:0]};

  // A write only lands while out of reset and not yet halted.
  assign wr_ok   = dmem_wr_en && nrst_in && !halted;
  assign ram_wr  = wr_ok && wr_in_ram;
  assign sig_wr  = wr_ok && (dmem_wr_addr == SIG_ADDR);
  assign halt_wr = wr_ok && (dmem_wr_addr == HALT_ADDR) && (dmem_wr_data == HALT_DATA);

  assign sig_full  = (sig_count == CW'(SIG_DEPTH));
  assign sig_valid = (sig_count != '0);
  assign pop       = sig_valid && sig_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = sig_wr && (!sig_full || pop);

  // Combinational read ports
  assign imem_data = imem_in_ram ? ram[imem_idx] : NOP;

  always_comb begin
    dmem_rd_data = '0;
    if (rd_in_ram) begin
      dmem_rd_data = ram[rd_idx];
    end else if (dmem_rd_addr == STAT_ADDR) begin
      dmem_rd_data = {halted, sig_overflow, 14'b0, {(16-CW){1'b0}}, sig_count};
    end
  end

  assign sig_data = sig_valid ? sig_fifo[rd_ptr] : '0;
  assign done     = halted && !sig_valid;

  // RAM write port; new data is visible to reads from the next cycle.
  always_ff @(posedge sysclk) begin
    if (ram_wr) begin
      ram[wr_idx] <= dmem_wr_data;
    end
  end

  // FIFO storage write
  always_ff @(posedge sysclk) begin
    if (push) begin
      sig_fifo[wr_ptr] <= dmem_wr_data;
    end
  end

  // FIFO pointers, occupancy and sticky status flags. Pointers wrap
  // naturally because SIG_DEPTH is a power of two.
  always_ff @(posedge sysclk or negedge nrst_in) begin
    if (!nrst_in) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      sig_count    <= '0;
      sig_overflow <= 1'b0;
      halted       <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   sig_count <= sig_count + 1'b1;
        2'b01:   sig_count <= sig_count - 1'b1;
        default: sig_count <= sig_count;
      endcase
      if (sig_wr && sig_full && !pop) begin
        sig_overflow <= 1'b1;
      end
      if (halt_wr) begin
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
Synthesizable memory-side responder for the core's split imem/dmem interface. It serves instruction fetches and data reads from a shared word RAM and absorbs data writes. It also decodes the memory-mapped signature and halt addresses in hardware. Signature words are buffered in a FIFO and streamed out over a valid/ready port to a UART or host drain, so the signature/halt protocol works on FPGA as well as in simulation.

Parameters:
MEMSIZE, 32, RAM depth in 32-bit words; power of two, at least 4.
SIG_DEPTH, 8, signature FIFO depth in words; power of two, at least 2.
SIG_ADDR, 32'hF0000004, signature write address.
STAT_ADDR, 32'hF0000008, status read address.
HALT_ADDR, 32'hCAFECAFE, halt write address.
HALT_DATA, 32'hF0000000, data value that qualifies a halt write.

Ports:
sysclk  in  1  system clock, rising edge.
nrst_in  in  1  asynchronous active-low reset.
imem_addr  in  32  instruction fetch byte address.
imem_data  out  32  instruction word; combinational.
dmem_rd_addr  in  32  data read byte address.
dmem_rd_data  out  32  read data; combinational.
dmem_wr_addr  in  32  data write byte address.
dmem_wr_data  in  32  write data.
dmem_wr_en  in  1  write strobe; sampled on sysclk rising edge.
sig_valid  out  1  signature word available.
sig_data  out  32  signature word at the FIFO head.
sig_ready  in  1  downstream accepts sig_data.
sig_overflow  out  1  sticky flag: a signature write was dropped.
halted  out  1  sticky flag: a halt write was seen.
done  out  1  halted AND FIFO empty.

Behaviour:
- Reset (asynchronous, nrst_in=0):
  - FIFO pointers and count cleared.
  - sig_valid=0, sig_overflow=0, halted=0, done=0, sig_data=0.
  - RAM contents are NOT reset.
  - Reset mid-drain discards FIFO contents.
- Address decoding:
  - AW = log2(MEMSIZE). RAM index = addr[AW+1:2].
  - RAM region is addr[31:28]==0. Higher index bits are ignored, so addresses alias modulo MEMSIZE words.
  - Byte offset bits [1:0] are ignored.
- Reads (zero latency, combinational):
  - imem_data = RAM[index] when imem_addr is in the RAM region, else 32'h00000013 (NOP).
  - dmem_rd_data = RAM[index] in the RAM region.
  - dmem_rd_addr==STAT_ADDR returns {halted, sig_overflow, 14'b0, 16-bit FIFO count, zero-extended}.
  - Any other dmem_rd_addr returns 0.
- Writes (only on a rising edge with dmem_wr_en=1, nrst_in=1, halted=0):
  - RAM region: RAM[index] <= dmem_wr_data. The new value is visible to reads in the next cycle.
  - dmem_wr_addr==SIG_ADDR: push dmem_wr_data into the FIFO if not full. If full, drop the word and set sig_overflow.
  - dmem_wr_addr==HALT_ADDR and dmem_wr_data==HALT_DATA: set halted.
  - HALT_ADDR with any other data, or any other address: ignored.
- Once halted=1, all writes are ignored, including further signature and halt writes. Draining continues.
- FIFO stream:
  - sig_valid = (count != 0). sig_data shows the head entry; it is 0 when empty.
  - A pop occurs on an edge with sig_valid AND sig_ready.
  - No fall-through: a push into an empty FIFO raises sig_valid on the following cycle.
  - Simultaneous push and pop when full: both take effect, count unchanged, no overflow.
  - Simultaneous push and pop when empty: push only; pop is impossible since sig_valid=0.
  - sig_data must hold stable while sig_valid=1 and sig_ready=0.
  - Pointers wrap modulo SIG_DEPTH.
- done rises the cycle after the last pop that follows halted=1, or the cycle after halted=1 if the FIFO is already empty.

Test Plan:
- RAM write/read and aliasing: reset, then write 0xDEADBEEF to 0x00000010 → dmem_rd_data at 0x10 is 0xDEADBEEF next cycle; reading 0x00000090 (MEMSIZE=32) returns the same value; imem_data at 0x10 matches.
- Signature order with backpressure: with sig_ready=0, write 0x11, 0x22, 0x33 to 0xF0000004 → STAT count=3. Raise sig_ready → sig_data 0x11, 0x22, 0x33 on consecutive cycles, then sig_valid=0.
- Overflow: with sig_ready=0, do 9 signature writes (SIG_DEPTH=8) → count=8, sig_overflow=1, the 9th word is absent from the drained stream, and STAT bit30=1.
- Full with simultaneous push and pop: fill the FIFO, then push 0x99 while sig_ready=1 → count stays 8, no overflow, 0x99 drained last.
- Halt qualification: write 0x12345678 to 0xCAFECAFE → halted stays 0. Write 0xF0000000 → halted=1 next cycle. A later RAM write to 0x0 is ignored. done=1 after the FIFO empties.
- Async reset mid-drain: with 5 words queued, pulse nrst_in low between clock edges → sig_valid=0, count=0, halted=0 immediately. RAM still holds the earlier 0xDEADBEEF.
